// File: rtl/rr_req_queue.sv
// ============================================================================
//  Module      : rr_req_queue
//  Description : Four per-channel FIFOs feeding a 4-way round-robin arbiter,
//                with a single registered, channel-tagged output.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            wr_en,
  input  logic [4*DATA_W-1:0]   wr_data,
  output logic [3:0]            full,
  output logic                  req0,
  output logic                  req1,
  output logic                  req2,
  output logic                  req3,
  input  logic                  gnt0,
  input  logic                  gnt1,
  input  logic                  gnt2,
  input  logic                  gnt3,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_ch,
  output logic [3:0]            ovf,
  output logic                  gnt_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0]             w_gnt;
  logic [3:0]             w_req;
  logic [3:0]             w_full;
  logic [3:0]             w_push;
  logic [3:0]             w_pop;
  logic [1:0]             w_sel;
  logic                   w_any;
  logic                   w_multi;
  logic                   w_pop_ok;
  logic                   w_gnt_bad;
  logic [3:0][DATA_W-1:0] w_head;

  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_out_data;
  logic [1:0]             r_out_ch;
  logic [3:0]             r_ovf;
  logic                   r_gnt_err;

  assign w_gnt = {gnt3, gnt2, gnt1, gnt0};

  // Lowest-index grant wins; a pop only happens if that channel has data.
  always_comb begin
    w_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_gnt[i]) w_sel = 2'(i);
    end
  end

  assign w_any     = |w_gnt;
  assign w_multi   = |(w_gnt & (w_gnt - 4'd1));
  assign w_pop_ok  = w_any && w_req[w_sel];
  assign w_gnt_bad = w_multi || (w_any && !w_req[w_sel]);
  assign w_pop     = w_pop_ok ? (4'b0001 << w_sel) : 4'b0000;
  assign w_push    = wr_en & ~w_full;

  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (w_push[n]) r_mem[r_wptr] <= wr_data[n*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[n]) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop[n])  r_rptr <= r_rptr + PTR_W'(1);
        if (w_push[n] && !w_pop[n])      r_cnt <= r_cnt + CNT_W'(1);
        else if (!w_push[n] && w_pop[n]) r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign w_full[n] = (r_cnt == CNT_W'(DEPTH));
    assign w_req[n]  = (r_cnt != '0);
    assign w_head[n] = r_mem[r_rptr];
  end : g_ch

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= 2'd0;
      r_ovf       <= 4'b0000;
      r_gnt_err   <= 1'b0;
    end else begin
      r_out_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_out_data <= w_head[w_sel];
        r_out_ch   <= w_sel;
      end
      // A full channel drops the push even if it pops on the same edge.
      r_ovf <= r_ovf | (wr_en & w_full);
      if (w_gnt_bad) r_gnt_err <= 1'b1;
    end
  end

  assign full      = w_full;
  assign req0      = w_req[0];
  assign req1      = w_req[1];
  assign req2      = w_req[2];
  assign req3      = w_req[3];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign ovf       = r_ovf;
  assign gnt_err   = r_gnt_err;

endmodule

`default_nettype wire

// File: tb/tb_rr_req_queue.sv
// ============================================================================
//  Module      : tb_rr_req_queue
//  Description : Self-checking bench for rr_req_queue with an output scoreboard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rr_req_queue;

  logic        clk;
  logic        rst;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  full;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic [3:0]  ovf;
  logic        gnt_err;

  int          errors = 0;
  int          checks = 0;
  logic [9:0]  sb[$];
  logic [9:0]  exp_beat;

  rr_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .req0      (req[0]),
    .req1      (req[1]),
    .req2      (req[2]),
    .req3      (req[3]),
    .gnt0      (gnt[0]),
    .gnt1      (gnt[1]),
    .gnt2      (gnt[2]),
    .gnt3      (gnt[3]),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .ovf       (ovf),
    .gnt_err   (gnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ch(input int ch, input logic [7:0] d);
    wr_en = 4'(1 << ch);
    wr_data[ch*8 +: 8] = d;
    tick();
    wr_en = 4'b0000;
  endtask

  // Grant one channel for one cycle and record the beat it must produce.
  task automatic grant_ch(input int ch, input logic [7:0] d);
    sb.push_back({2'(ch), d});
    gnt = 4'(1 << ch);
    tick();
    gnt = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 4'hF;
      gnt     = 4'(i + 5);
      wr_data = $urandom;
      tick();
    end
    checks++;
    if ({full, req, out_valid, out_data, out_ch, ovf, gnt_err} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: full=%b req=%b ov=%b od=%h oc=%0d ovf=%b ge=%b, required all 0",
               full, req, out_valid, out_data, out_ch, ovf, gnt_err);
    end
    gnt     = 4'b0000;
    wr_en   = 4'b0100;
    wr_data = 32'h00A5_0000;
    rst     = 1'b1;
    tick();
    wr_en = 4'b0000;
    checks++;
    if (req !== 4'b0100) begin
      errors++;
      $display("FAIL reset_first_push: req=%b, required 0100", req);
    end
    grant_ch(2, 8'hA5);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL reset_pop: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat) begin
        errors++;
        $display("FAIL reset_pop: ch=%0d data=%h, required ch=%0d data=%h",
                 out_ch, out_data, exp_beat[9:8], exp_beat[7:0]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= 4; k++) push_ch(0, 8'(k));
    checks++;
    if (full !== 4'b0001) begin
      errors++;
      $display("FAIL fill_full: full=%b, required 0001", full);
    end
    push_ch(0, 8'd5);
    checks++;
    if (ovf !== 4'b0001 || full[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_ovf: ovf=%b full=%b, required ovf=0001 full[0]=1", ovf, full);
    end
    for (int k = 1; k <= 4; k++) begin
      grant_ch(0, 8'(k));
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL fill_drain%0d: out_valid=%b, required 1", k, out_valid);
      end else begin
        exp_beat = sb.pop_front();
        if ({out_ch, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL fill_drain%0d: ch=%0d data=%h, required ch=%0d data=%h",
                   k, out_ch, out_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
    checks++;
    if (req[0] !== 1'b0 || full !== 4'b0000) begin
      errors++;
      $display("FAIL fill_empty: req0=%b full=%b, required req0=0 full=0000", req[0], full);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd4 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL fill_hold: ov=%b data=%h ch=%0d, required ov=0 data=04 ch=0",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) push_ch(1, 8'(8'h10 + k));
    for (int k = 0; k < 3; k++) grant_ch(1, 8'(8'h10 + k));
    for (int k = 3; k < 7; k++) push_ch(1, 8'(8'h10 + k));
    checks++;
    if (full[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: full=%b, required full[1]=1", full);
    end
    for (int k = 3; k < 7; k++) grant_ch(1, 8'(8'h10 + k));
    // The first three beats were produced before the refill; check all seven now
    // by replaying: only the last beat is still on the output, so compare it
    // and the scoreboard bookkeeping separately.
    checks++;
    if (out_valid !== 1'b1 || {out_ch, out_data} !== {2'd1, 8'h16}) begin
      errors++;
      $display("FAIL wrap_last: ov=%b ch=%0d data=%h, required ov=1 ch=1 data=16",
               out_valid, out_ch, out_data);
    end
    sb.delete();
    checks++;
    if (req[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: req1=%b, required 0", req[1]);
    end
  endtask

  task automatic test_wrap_order();
    // Pointers of ch1 now sit at 7 mod 4 = 3; check every beat across another wrap.
    for (int k = 0; k < 3; k++) push_ch(1, 8'(8'h20 + k));
    for (int k = 0; k < 3; k++) begin
      grant_ch(1, 8'(8'h20 + k));
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL wrap_order%0d: out_valid=%b, required 1", k, out_valid);
      end else begin
        exp_beat = sb.pop_front();
        if ({out_ch, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL wrap_order%0d: ch=%0d data=%h, required ch=%0d data=%h",
                   k, out_ch, out_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    push_ch(3, 8'h30);
    push_ch(3, 8'h31);
    sb.push_back({2'd3, 8'h30});
    wr_en = 4'b1000;
    wr_data[31:24] = 8'h32;
    gnt = 4'b1000;
    tick();
    wr_en = 4'b0000;
    gnt   = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL same_pop: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat || req[3] !== 1'b1 || full[3] !== 1'b0) begin
        errors++;
        $display("FAIL same_pop: ch=%0d data=%h req3=%b full3=%b, required ch=3 data=30 req3=1 full3=0",
                 out_ch, out_data, req[3], full[3]);
      end
    end
    for (int k = 1; k <= 2; k++) begin
      grant_ch(3, 8'(8'h30 + k));
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL same_drain%0d: out_valid=%b, required 1", k, out_valid);
      end else begin
        exp_beat = sb.pop_front();
        if ({out_ch, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL same_drain%0d: ch=%0d data=%h, required ch=%0d data=%h",
                   k, out_ch, out_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
    checks++;
    if (req[3] !== 1'b0) begin
      errors++;
      $display("FAIL same_cnt: req3=%b, required 0 (count must have stayed 2)", req[3]);
    end
    for (int k = 3; k <= 6; k++) push_ch(3, 8'(8'h30 + k));
    sb.push_back({2'd3, 8'h33});
    wr_en = 4'b1000;
    wr_data[31:24] = 8'h37;
    gnt = 4'b1000;
    tick();
    wr_en = 4'b0000;
    gnt   = 4'b0000;
    checks++;
    if (ovf !== 4'b1001 || full[3] !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: ovf=%b full=%b, required ovf=1001 full[3]=0", ovf, full);
    end
    for (int k = 4; k <= 6; k++) begin
      if (k > 4) begin end
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL full_drain%0d: out_valid=%b, required 1", k, out_valid);
      end else begin
        checks++;
        exp_beat = sb.pop_front();
        if ({out_ch, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL full_drain%0d: ch=%0d data=%h, required ch=%0d data=%h",
                   k, out_ch, out_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
      grant_ch(3, 8'(8'h30 + k));
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL full_last: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat || req[3] !== 1'b0) begin
        errors++;
        $display("FAIL full_last: ch=%0d data=%h req3=%b, required ch=3 data=36 req3=0",
                 out_ch, out_data, req[3]);
      end
    end
  endtask

  task automatic test_errors();
    checks++;
    if (gnt_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: gnt_err=%b, required 0", gnt_err);
    end
    wr_en   = 4'b0101;
    wr_data = 32'h0042_0040;
    tick();
    wr_en = 4'b0000;
    sb.push_back({2'd0, 8'h40});
    gnt = 4'b0101;
    tick();
    gnt = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL err_multi: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat || gnt_err !== 1'b1 || req[2] !== 1'b1) begin
        errors++;
        $display("FAIL err_multi: ch=%0d data=%h ge=%b req2=%b, required ch=0 data=40 ge=1 req2=1",
                 out_ch, out_data, gnt_err, req[2]);
      end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (gnt_err !== 1'b0 || ovf !== 4'b0000 || req !== 4'b0000) begin
      errors++;
      $display("FAIL err_reset: ge=%b ovf=%b req=%b, required all 0", gnt_err, ovf, req);
    end
    gnt = 4'b0010;
    tick();
    gnt = 4'b0000;
    checks++;
    if (out_valid !== 1'b0 || gnt_err !== 1'b1) begin
      errors++;
      $display("FAIL err_empty: ov=%b ge=%b, required ov=0 ge=1", out_valid, gnt_err);
    end
  endtask

  task automatic test_async_reset();
    wr_en   = 4'b0011;
    wr_data = 32'h0000_6050;
    tick();
    push_ch(0, 8'h51);
    grant_ch(0, 8'h50);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL async_pre: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat) begin
        errors++;
        $display("FAIL async_pre: ch=%0d data=%h, required ch=0 data=50", out_ch, out_data);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (req !== 4'b0000 || full !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_now: req=%b full=%b ov=%b, required all 0", req, full, out_valid);
    end
    rst = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      gnt = 4'(1 << c);
      tick();
      gnt = 4'b0000;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL async_stale%0d: out_valid=%b data=%h, required out_valid=0",
                 c, out_valid, out_data);
      end
    end
    push_ch(0, 8'h70);
    grant_ch(0, 8'h70);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL async_after: out_valid=%b, required 1", out_valid);
    end else begin
      exp_beat = sb.pop_front();
      if ({out_ch, out_data} !== exp_beat) begin
        errors++;
        $display("FAIL async_after: ch=%0d data=%h, required ch=0 data=70", out_ch, out_data);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    rst     = 1'b0;
    wr_en   = 4'b0000;
    wr_data = 32'd0;
    gnt     = 4'b0000;
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_wrap_order();
    test_same_cycle();
    test_errors();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
